// File: rtl/arm_mul_pkg.sv
// Shared encodings, FSM states and cycle-count helper for the iterative multiplier.
package arm_mul_pkg;

  localparam logic [1:0] MUL_OP   = 2'b00;
  localparam logic [1:0] MLA_OP   = 2'b01;
  localparam logic [1:0] UMULL_OP = 2'b10;
  localparam logic [1:0] SMULL_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_t;

  function automatic int calc_n(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/arm_mul_step.sv
// One shift-add iteration: folds i_a * i_bits into the upper half of the
// accumulator, then shifts the whole accumulator right by BPC.
module arm_mul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [BPC-1:0]     i_bits,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH+BPC-1:0] w_pp;
  logic [WIDTH+BPC-1:0] w_sum;
  logic                 w_unused_lo;

  assign w_pp  = {{BPC{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_bits};
  assign w_sum = {{BPC{1'b0}}, i_acc[2*WIDTH-1:WIDTH]} + w_pp;

  // The low BPC bits fall off the bottom; after N steps the low half holds
  // exactly the retired product bits.
  assign w_unused_lo = ^i_acc[BPC-1:0];

  generate
    if (BPC < WIDTH) begin : g_shift
      assign o_acc = {w_sum, i_acc[WIDTH-1:BPC]};
    end else begin : g_full
      assign o_acc = w_sum;
    end
  endgenerate

endmodule

// File: rtl/arm_mul_unit.sv
// Iterative MUL/MLA/UMULL/SMULL unit for Execute; stalls the pipe via BusyE
// and pulses DoneM for one cycle when the registered result is ready.
module arm_mul_unit
  import arm_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       MulOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] AccE,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             DoneM,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags
);

  localparam int N  = calc_n(WIDTH, BPC);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_t         r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_accv;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_start, w_accept, w_smull, w_long;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_mla, w_lo, w_hi;
  logic [2*WIDTH-1:0] w_step, w_prod;
  logic               w_n, w_z;

  assign w_start  = StartE & ~FlushE;
  assign w_accept = w_start & ((r_state == IDLE) | (r_state == DONE));
  assign BusyE    = (r_state == RUN) | (r_state == FIX) | w_accept;
  assign DoneM    = (r_state == DONE);

  // SMULL runs the unsigned datapath on magnitudes and fixes the sign in FIX.
  assign w_smull = (MulOpE == SMULL_OP);
  assign w_abs_a = (w_smull & SrcAE[WIDTH-1]) ? (~SrcAE + WIDTH'(1)) : SrcAE;
  assign w_abs_b = (w_smull & SrcBE[WIDTH-1]) ? (~SrcBE + WIDTH'(1)) : SrcBE;

  arm_mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .i_acc  (r_acc),
    .i_a    (r_a),
    .i_bits (r_b[BPC-1:0]),
    .o_acc  (w_step)
  );

  assign w_prod = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
  assign w_mla  = r_acc[WIDTH-1:0] + r_accv;
  assign w_long = (r_op == UMULL_OP) | (r_op == SMULL_OP);

  always_comb begin
    w_lo = r_acc[WIDTH-1:0];
    w_hi = '0;
    case (r_op)
      MLA_OP:             w_lo = w_mla;
      UMULL_OP, SMULL_OP: {w_hi, w_lo} = w_prod;
      default:            w_lo = r_acc[WIDTH-1:0];
    endcase
    w_n = w_long ? w_hi[WIDTH-1] : w_lo[WIDTH-1];
    w_z = w_long ? (w_prod == '0) : (w_lo == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= MUL_OP;
      r_a      <= '0;
      r_b      <= '0;
      r_accv   <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulFlags <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state <= RUN;
            r_op    <= MulOpE;
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_accv  <= AccE;
            r_neg   <= w_smull & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (FlushE) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_step;
            r_b   <= r_b >> BPC;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) r_state <= FIX;
          end
        end
        FIX: begin
          if (FlushE) begin
            r_state <= IDLE;
          end else begin
            ResultLo <= w_lo;
            ResultHi <= w_hi;
            MulFlags <= {w_n, w_z};
            r_state  <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mul_unit.sv
// Directed scoreboard bench for arm_mul_unit: a BPC=1 and a BPC=4 instance
// share stimulus, with sel choosing which one receives StartE and is observed.
module tb_arm_mul_unit;
  import arm_mul_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  fl;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, start, flush, sel;
  logic [1:0]  op;
  logic [31:0] a, b, acc;

  logic        busy1, done1, busy4, done4;
  logic [31:0] lo1, hi1, lo4, hi4;
  logic [1:0]  fl1, fl4;

  logic        busy, done;
  logic [31:0] lo, hi;
  logic [1:0]  fl;

  res_t sbq[$];
  res_t last_exp, exp_r;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  assign busy = sel ? busy4 : busy1;
  assign done = sel ? done4 : done1;
  assign lo   = sel ? lo4 : lo1;
  assign hi   = sel ? hi4 : hi1;
  assign fl   = sel ? fl4 : fl1;

  arm_mul_unit #(.WIDTH(32), .BPC(1)) dut1 (
    .clk(clk), .reset(reset), .StartE(start & ~sel), .MulOpE(op),
    .SrcAE(a), .SrcBE(b), .AccE(acc), .FlushE(flush),
    .BusyE(busy1), .DoneM(done1), .ResultLo(lo1), .ResultHi(hi1), .MulFlags(fl1)
  );

  arm_mul_unit #(.WIDTH(32), .BPC(4)) dut4 (
    .clk(clk), .reset(reset), .StartE(start & sel), .MulOpE(op),
    .SrcAE(a), .SrcBE(b), .AccE(acc), .FlushE(flush),
    .BusyE(busy4), .DoneM(done4), .ResultLo(lo4), .ResultHi(hi4), .MulFlags(fl4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] z);
    res_t        r;
    logic [63:0] p;
    longint      sx, sy;
    r = '0;
    case (o)
      MUL_OP: begin
        p = {32'd0, x} * {32'd0, y};
        r.lo = p[31:0];
      end
      MLA_OP: begin
        p = {32'd0, x} * {32'd0, y} + {32'd0, z};
        r.lo = p[31:0];
      end
      UMULL_OP: begin
        p = {32'd0, x} * {32'd0, y};
        {r.hi, r.lo} = p;
      end
      default: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'(sx * sy);
        {r.hi, r.lo} = p;
      end
    endcase
    if (o == UMULL_OP || o == SMULL_OP) r.fl = {r.hi[31], ({r.hi, r.lo} == 64'd0)};
    else                                r.fl = {r.lo[31], (r.lo == 32'd0)};
    return r;
  endfunction

  // Drives a start in the current cycle, checks the same-cycle stall, then
  // scrambles operands after the accepting edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z, input string tag);
    start = 1'b1; op = o; a = x; b = y; acc = z;
    sbq.push_back(model(o, x, y, z));
    #1 chk({tag, "_busy_c0"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    acc   = $urandom;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int c;
    bit seen, busy_ok;
    seen = 0; busy_ok = 1; c = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      c = i;
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    exp_r = sbq.pop_front();
    if (seen) begin
      chk({tag, "_latency"}, 64'(c), 64'(lat));
      chk({tag, "_busy_until_done"}, 64'(busy_ok), 64'd1);
      chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
      chk({tag, "_lo"}, 64'(lo), 64'(exp_r.lo));
      chk({tag, "_hi"}, 64'(hi), 64'(exp_r.hi));
      chk({tag, "_flags"}, 64'(fl), 64'(exp_r.fl));
      last_exp = exp_r;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; sel = 1'b0;
    op = MUL_OP; a = '0; b = '0; acc = '0;
    last_exp = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_flags", 64'(fl), 64'd0);
    @(negedge clk) reset = 1'b0;

    // BPC=1: DoneM lands in cycle N+2 = 34
    @(negedge clk); start_op(MUL_OP, 32'd7, 32'd6, 32'd0, "mul7x6");
    wait_done(34, "mul7x6");
    chk("mul7x6_lo_const", 64'(lo), 64'h2A);
    @(negedge clk); start_op(UMULL_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, "umull_max");
    wait_done(34, "umull_max");
    chk("umull_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    @(negedge clk); start_op(SMULL_OP, 32'hFFFFFFFD, 32'd5, 32'd0, "smull_neg");
    wait_done(34, "smull_neg");
    chk("smull_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge clk); start_op(SMULL_OP, 32'h80000000, 32'h80000000, 32'd0, "smull_min");
    wait_done(34, "smull_min");
    chk("smull_min_const", {hi, lo}, 64'h40000000_00000000);
    @(negedge clk); start_op(MUL_OP, 32'd0, 32'h1234, 32'd0, "mul_zero");
    wait_done(34, "mul_zero");
    chk("mul_zero_flags", 64'(fl), 64'd1);
    @(negedge clk); start_op(MLA_OP, 32'h00010000, 32'h00010000, 32'd5, "mla_wrap");
    wait_done(34, "mla_wrap");
    chk("mla_wrap_lo_const", 64'(lo), 64'd5);

    // Flush in RUN cycle 10: busy drops in cycle 11, no DoneM, results held
    @(negedge clk);
    start = 1'b1; op = MUL_OP; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_busy_c10", 64'(busy), 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_c11", 64'(busy), 64'd0);
    begin
      bit any_done;
      any_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) any_done = 1;
      end
      chk("flush_no_done", 64'(any_done), 64'd0);
    end
    chk("flush_hold_lo", 64'(lo), 64'(last_exp.lo));
    chk("flush_hold_hi", 64'(hi), 64'(last_exp.hi));
    chk("flush_hold_flags", 64'(fl), 64'(last_exp.fl));

    // Asynchronous reset mid-RUN clears outputs before any clock edge
    @(negedge clk);
    start = 1'b1; op = UMULL_OP; a = 32'h1234; b = 32'h10;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_flags", 64'(fl), 64'd0);
    @(negedge clk) reset = 1'b0;

    // BPC=4 instance: DoneM at cycle 10, back-to-back start in DONE
    sel = 1'b1;
    @(negedge clk); start_op(UMULL_OP, 32'h12345678, 32'h9ABCDEF0, 32'd0, "b4_umull");
    wait_done(10, "b4_umull");
    start_op(SMULL_OP, 32'hFFFFFFFD, 32'd5, 32'd0, "b4_b2b_smull");
    wait_done(10, "b4_b2b_smull");
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MUL_OP; a = 32'd9; b = 32'd9;
    #1 chk("b4_flushstart_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("b4_flushstart_idle", 64'(busy), 64'd0);
    chk("b4_flushstart_nodone", 64'(done), 64'd0);
    start_op(MLA_OP, 32'hDEADBEEF, 32'h00000003, 32'h11111111, "b4_mla");
    wait_done(10, "b4_mla");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
